// File: rtl/mem_line_xfer.sv
// mem_line_xfer: turns single-cycle cache requests into word-serial line writeback/fill bursts on a main-memory port.
// Optional MEM_LINE_XFER_STAT_EN adds saturating completed-writeback/fill counters.
module mem_line_xfer #(
  parameter int ADDR_LEN      = 11,
  parameter int LINE_ADDR_LEN = 3,
  localparam int TAG_LEN      = ADDR_LEN - LINE_ADDR_LEN
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_wb,
  input  logic [TAG_LEN-1:0]       wb_line_addr,
  input  logic                     req_fill,
  input  logic [TAG_LEN-1:0]       fill_line_addr,
  output logic [LINE_ADDR_LEN-1:0] wb_idx,
  input  logic [31:0]              wb_word,
  output logic                     fill_valid,
  output logic [LINE_ADDR_LEN-1:0] fill_idx,
  output logic [31:0]              fill_data,
  output logic                     busy,
  output logic                     done,
  output logic [ADDR_LEN-1:0]      mem_addr,
  output logic                     mem_wr_req,
  output logic [31:0]              mem_wr_data,
  input  logic [31:0]              mem_rd_data
`ifdef MEM_LINE_XFER_STAT_EN
  ,
  output logic [15:0]              stat_wb_cnt,
  output logic [15:0]              stat_fill_cnt
`endif
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WB   = 3'd1;
  localparam logic [2:0] S_FILL = 3'd2;
  localparam logic [2:0] S_TAIL = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  logic [2:0]               r_state;
  logic [LINE_ADDR_LEN-1:0] r_idx;
  logic                     r_pend_fill;
  logic [TAG_LEN-1:0]       r_wb_line;
  logic [TAG_LEN-1:0]       r_fill_line;
  logic                     w_wb;
  logic                     w_fill;
  assign w_wb       = r_state == S_WB;
  assign w_fill     = r_state == S_FILL;
  assign busy       = r_state != S_IDLE;
  assign done       = r_state == S_DONE;
  assign wb_idx     = r_idx;
  // The first FILL cycle has no read data yet; the tail cycle sees idx already wrapped to 0.
  assign fill_valid = (w_fill && r_idx != '0) || r_state == S_TAIL;
  assign fill_idx   = fill_valid ? r_idx - 1'b1 : '0;
  assign fill_data  = fill_valid ? mem_rd_data : '0;
  assign mem_addr   = w_wb ? {r_wb_line, r_idx} : w_fill ? {r_fill_line, r_idx} : '0;
  // Gated by rst so the cycle carrying the reset never commits another word.
  assign mem_wr_req = w_wb & ~rst;
  assign mem_wr_data = w_wb ? wb_word : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_pend_fill <= 1'b0;
      r_wb_line   <= '0;
      r_fill_line <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (req_wb || req_fill) begin
          r_wb_line   <= wb_line_addr;
          r_fill_line <= fill_line_addr;
          r_pend_fill <= req_fill;
          r_idx       <= '0;
          r_state     <= req_wb ? S_WB : S_FILL;
        end
        S_WB: begin
          r_idx <= r_idx + 1'b1;
          if (&r_idx) r_state <= r_pend_fill ? S_FILL : S_DONE;
        end
        S_FILL: begin
          r_idx <= r_idx + 1'b1;
          if (&r_idx) r_state <= S_TAIL;
        end
        S_TAIL:  r_state <= S_DONE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
`ifdef MEM_LINE_XFER_STAT_EN
  logic r_pend_wb;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_wb     <= 1'b0;
      stat_wb_cnt   <= '0;
      stat_fill_cnt <= '0;
    end else begin
      if (r_state == S_IDLE && (req_wb || req_fill)) r_pend_wb <= req_wb;
      if (done && r_pend_wb && ~&stat_wb_cnt) stat_wb_cnt <= stat_wb_cnt + 16'd1;
      if (done && r_pend_fill && ~&stat_fill_cnt) stat_fill_cnt <= stat_fill_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_mem_line_xfer.sv
// tb_mem_line_xfer: directed bench for mem_line_xfer with a registered-read memory model and an index-addressed victim buffer.
module tb_mem_line_xfer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b1;
  logic        req_wb = 1'b0;
  logic [7:0]  wb_line_addr = '0;
  logic        req_fill = 1'b0;
  logic [7:0]  fill_line_addr = '0;
  logic [2:0]  wb_idx;
  logic [31:0] wb_word;
  logic [31:0] wb_base = '0;
  logic        fill_valid;
  logic [2:0]  fill_idx;
  logic [31:0] fill_data;
  logic        busy;
  logic        done;
  logic [10:0] mem_addr;
  logic        mem_wr_req;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_rd_data;
`ifdef MEM_LINE_XFER_STAT_EN
  logic [15:0] stat_wb_cnt;
  logic [15:0] stat_fill_cnt;
`endif
  logic [31:0] init_tbl [16] = '{32'h5e, 32'hb8, 32'h51, 32'h21, 32'hff, 32'h7a, 32'h33, 32'he4,
                                 32'hfa, 32'h4e, 32'hc0, 32'h93, 32'hbb, 32'he9, 32'h41, 32'h81};
  logic [31:0] mem [2048];
  logic [31:0] r_busy [25];
  logic [31:0] r_done [25];
  logic [31:0] r_fv [25];
  logic [31:0] r_fidx [25];
  logic [31:0] r_fdat [25];
  logic [31:0] r_wr [25];
  logic [31:0] r_addr [25];
  int n_cmp = 0;
  int n_err = 0;

  mem_line_xfer dut (
    .clk(clk), .rst(rst),
    .req_wb(req_wb), .wb_line_addr(wb_line_addr),
    .req_fill(req_fill), .fill_line_addr(fill_line_addr),
    .wb_idx(wb_idx), .wb_word(wb_word),
    .fill_valid(fill_valid), .fill_idx(fill_idx), .fill_data(fill_data),
    .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_wr_req(mem_wr_req), .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
`ifdef MEM_LINE_XFER_STAT_EN
    , .stat_wb_cnt(stat_wb_cnt), .stat_fill_cnt(stat_fill_cnt)
`endif
  );

  always #5 clk = ~clk;
  assign wb_word = wb_base + {29'd0, wb_idx};

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 2048; i++) mem[i] <= (i < 16) ? init_tbl[i] : 32'd0;
    end else if (mem_wr_req) begin
      mem[mem_addr] <= mem_wr_data;
    end
    mem_rd_data <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rec(input int k);
    r_busy[k] = 32'(busy);
    r_done[k] = 32'(done);
    r_fv[k]   = 32'(fill_valid);
    r_fidx[k] = 32'(fill_idx);
    r_fdat[k] = fill_data;
    r_wr[k]   = 32'(mem_wr_req);
    r_addr[k] = 32'(mem_addr);
  endtask

  // Cycle 0 carries the request; inj re-pulses req_fill to line 2, rstc asserts rst for one cycle.
  task automatic xfer(input logic wb, input logic fl, input logic [7:0] wl, input logic [7:0] fla,
                      input logic [31:0] base, input int n, input int inj, input int rstc);
    @(posedge clk); #1;
    req_wb = wb; req_fill = fl; wb_line_addr = wl; fill_line_addr = fla; wb_base = base;
    @(negedge clk); rec(0);
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      req_wb = 1'b0;
      req_fill = (k == inj);
      if (k == inj) fill_line_addr = 8'd2;
      rst = (k == rstc);
      @(negedge clk); rec(k);
    end
    rst = 1'b0; req_fill = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_fv", 32'(fill_valid), 0);
    chk("rst_wr", 32'(mem_wr_req), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_fdat", fill_data, 0);
    rst = 1'b0; load = 1'b0;

    // Reset in cycle 4 of a line-0 writeback.
    xfer(1'b1, 1'b0, 8'd0, 8'd0, 32'hC0, 7, 0, 4);
    for (int k = 1; k <= 3; k++) chk("rwb_wr", r_wr[k], 1);
    for (int k = 5; k <= 7; k++) begin
      chk("rwb_busy", r_busy[k], 0);
      chk("rwb_wr_off", r_wr[k], 0);
    end
    for (int k = 0; k <= 7; k++) chk("rwb_nodone", r_done[k], 0);
    for (int i = 0; i < 3; i++) chk("rwb_written", mem[i], 32'hC0 + i);
    for (int i = 3; i < 8; i++) chk("rwb_kept", mem[i], init_tbl[i]);

    // Fill only, line 1.
    xfer(1'b0, 1'b1, 8'd0, 8'd1, 32'h0, 12, 0, 0);
    for (int k = 0; k <= 12; k++) begin
      chk("fo_busy", r_busy[k], (k >= 1 && k <= 10) ? 1 : 0);
      chk("fo_done", r_done[k], (k == 10) ? 1 : 0);
      chk("fo_fv", r_fv[k], (k >= 2 && k <= 9) ? 1 : 0);
      chk("fo_wr", r_wr[k], 0);
      if (k >= 2 && k <= 9) begin
        chk("fo_fidx", r_fidx[k], k - 2);
        chk("fo_fdat", r_fdat[k], init_tbl[8 + k - 2]);
      end
      if (k >= 1 && k <= 8) chk("fo_addr", r_addr[k], 8 + k - 1);
    end

    // Writeback only, line 0, victim words 0x100+idx.
    xfer(1'b1, 1'b0, 8'd0, 8'd0, 32'h100, 11, 0, 0);
    for (int k = 0; k <= 11; k++) begin
      chk("wo_wr", r_wr[k], (k >= 1 && k <= 8) ? 1 : 0);
      chk("wo_done", r_done[k], (k == 9) ? 1 : 0);
      chk("wo_fv", r_fv[k], 0);
      if (k >= 1 && k <= 8) chk("wo_addr", r_addr[k], k - 1);
    end
    for (int i = 0; i < 8; i++) chk("wo_mem", mem[i], 32'h100 + i);
    chk("wo_line1_kept", mem[8], 32'hfa);

    // Combined writeback+fill of line 0, victim words 0xA0+idx.
    xfer(1'b1, 1'b1, 8'd0, 8'd0, 32'hA0, 20, 0, 0);
    for (int k = 0; k <= 20; k++) begin
      chk("cb_done", r_done[k], (k == 18) ? 1 : 0);
      chk("cb_wr", r_wr[k], (k >= 1 && k <= 8) ? 1 : 0);
      chk("cb_fv", r_fv[k], (k >= 10 && k <= 17) ? 1 : 0);
      chk("cb_busy", r_busy[k], (k >= 1 && k <= 18) ? 1 : 0);
      if (k >= 10 && k <= 17) begin
        chk("cb_fidx", r_fidx[k], k - 10);
        chk("cb_fdat", r_fdat[k], 32'hA0 + k - 10);
      end
    end

    // Fill line 1 with an ignored fill request to line 2 in cycle 4.
    xfer(1'b0, 1'b1, 8'd0, 8'd1, 32'h0, 12, 4, 0);
    for (int k = 0; k <= 12; k++) begin
      chk("bi_done", r_done[k], (k == 10) ? 1 : 0);
      chk("bi_busy", r_busy[k], (k >= 1 && k <= 10) ? 1 : 0);
      chk("bi_no_line2", 32'(r_addr[k][10:3]), (r_busy[k] != 0 && k <= 8) ? 1 : 0);
      if (k >= 2 && k <= 9) chk("bi_fdat", r_fdat[k], init_tbl[8 + k - 2]);
    end

`ifdef MEM_LINE_XFER_STAT_EN
    chk("st_fill", 32'(stat_fill_cnt), 3);
    chk("st_wb", 32'(stat_wb_cnt), 2);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("st_fill_rst", 32'(stat_fill_cnt), 0);
    chk("st_wb_rst", 32'(stat_wb_cnt), 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
